// File: rtl/out_bram_reader.sv
// out_bram_reader: streams a run of BRAM words onto a valid/ready master through a 2-entry buffer.
// Defining OUT_RD_XOR_CHK_EN adds a chk port carrying the running XOR of the run's beats.
module out_bram_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_re,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef OUT_RD_XOR_CHK_EN
    ,
    output logic [DATA_WIDTH-1:0] chk
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;
    state_t                state;
    logic [LEN_WIDTH-1:0]  len_sat, rd_left, beats_left;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic                  head, inflight, pop;
    logic [1:0]            cnt;
    assign len_sat = len > MAX_LEN ? MAX_LEN : len;
    assign m_valid = cnt != 2'd0;
    assign m_data  = fifo[head];
    assign m_last  = m_valid && beats_left == LEN_WIDTH'(1);
    assign pop     = m_valid && m_ready;
    // A read is only issued if its data is sure to find a free slot one cycle after it returns.
    assign bram_re = state == RUN && (3'(cnt) + 3'(inflight)) < (3'd2 + 3'(pop));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bram_rd_addr <= '0;
            rd_left      <= '0;
            beats_left   <= '0;
            head         <= 1'b0;
            cnt          <= 2'd0;
            inflight     <= 1'b0;
            fifo[0]      <= '0;
            fifo[1]      <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= bram_re;
            cnt      <= cnt + 2'(inflight) - 2'(pop);
            if (inflight) fifo[head ^ cnt[0]] <= bram_rd_data;
            if (pop) begin
                head       <= ~head;
                beats_left <= beats_left - LEN_WIDTH'(1);
            end
            if (bram_re) begin
                bram_rd_addr <= bram_rd_addr + ADDR_WIDTH'(1);
                rd_left      <= rd_left - LEN_WIDTH'(1);
            end
            case (state)
                IDLE: if (start) begin
                    bram_rd_addr <= base_addr;
                    rd_left      <= len_sat;
                    beats_left   <= len_sat;
                    busy         <= len_sat != '0;
                    done         <= len_sat == '0;
                    state        <= len_sat == '0 ? FIN : RUN;
                end
                RUN: if (bram_re && rd_left == LEN_WIDTH'(1)) state <= DRAIN;
                DRAIN: if (pop && beats_left == LEN_WIDTH'(1)) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef OUT_RD_XOR_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk <= '0;
        else if (state == IDLE && start) chk <= '0;
        else if (pop) chk <= chk ^ m_data;
    end
`endif
endmodule
